// File: rtl/game_pkg.sv
// Shared types and helpers for the N x N, K-in-a-row board game controller.
// Width helpers let every module derive its field widths from N, K and PLAYERS.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_e;

    localparam int EMPTY    = 0;
    localparam int NUM_DIRS = 4;

    // Direction table: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal
    function automatic int dirDr(input logic [1:0] dir);
        return (dir == 2'd0) ? 0 : 1;
    endfunction

    function automatic int dirDc(input logic [1:0] dir);
        case (dir)
            2'd0:    return 1;
            2'd1:    return 0;
            2'd2:    return 1;
            default: return -1;
        endcase
    endfunction

    function automatic int cellWidth(input int players);
        return $clog2(players + 1);
    endfunction

    function automatic int coordWidth(input int n);
        return $clog2(n);
    endfunction

    function automatic int countWidth(input int n);
        return $clog2(n * n + 1);
    endfunction

    // A run through the anchor is at most 2K-1 cells long
    function automatic int runWidth(input int k);
        return $clog2(2 * k);
    endfunction

endpackage

// File: rtl/line_run_counter.sv
// Combinational run-length counter: counts same-owner cells through an anchor
// along one direction, each side capped at K-1 and stopped by edges or other codes.
module line_run_counter
    import game_pkg::*;
#(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int CW = 2,
    parameter int IW = 2,
    localparam int RW = runWidth(K)
) (
    input  logic [N*N*CW-1:0] board_i,
    input  logic [IW-1:0]     anchorRow_i,
    input  logic [IW-1:0]     anchorCol_i,
    input  logic [CW-1:0]     owner_i,
    input  logic [1:0]        dir_i,
    output logic [RW-1:0]     run_o
);

    // Cell lookup is a match over every cell so no runtime index is needed
    always_comb begin
        int dr;
        int dc;
        int r;
        int c;
        int total;
        logic blocked;
        logic [CW-1:0] cellVal;

        dr      = dirDr(dir_i);
        dc      = dirDc(dir_i);
        r       = 0;
        c       = 0;
        total   = 1;
        blocked = 1'b0;
        cellVal = '0;

        for (int side = 0; side < 2; side++) begin
            blocked = 1'b0;
            for (int step = 1; step < K; step++) begin
                r = int'(anchorRow_i) + ((side == 0) ? step * dr : -(step * dr));
                c = int'(anchorCol_i) + ((side == 0) ? step * dc : -(step * dc));
                cellVal = '0;
                for (int i = 0; i < N * N; i++) begin
                    if (i == r * N + c) begin
                        cellVal = board_i[i*CW +: CW];
                    end
                end
                if (!blocked) begin
                    if (r < 0 || r >= N || c < 0 || c >= N) begin
                        blocked = 1'b1;
                    end else if (cellVal != owner_i) begin
                        blocked = 1'b1;
                    end else begin
                        total = total + 1;
                    end
                end
            end
        end

        run_o = RW'(total);
    end

endmodule

// File: rtl/board_game_ctrl.sv
// Board game controller: owns board, turn order and result flags, takes moves
// over a valid/ready handshake and checks one direction per cycle after each move.
module board_game_ctrl
    import game_pkg::*;
#(
    parameter int N       = 3,
    parameter int K       = 3,
    parameter int PLAYERS = 2,
    localparam int CW = cellWidth(PLAYERS),
    localparam int IW = coordWidth(N),
    localparam int MW = countWidth(N),
    localparam int RW = runWidth(K)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              move_valid,
    input  logic [IW-1:0]     move_row,
    input  logic [IW-1:0]     move_col,
    output logic              move_ready,
    output logic              move_accept,
    output logic              move_reject,
    output logic [N*N*CW-1:0] board,
    output logic [CW-1:0]     current_player,
    output logic [MW-1:0]     move_count,
    output logic [CW-1:0]     winner,
    output logic              draw,
    output logic              game_over
);

    state_e              state_q;
    logic [N*N*CW-1:0]   board_q;
    logic [CW-1:0]       player_q;
    logic [MW-1:0]       count_q;
    logic [CW-1:0]       winner_q;
    logic                draw_q;
    logic [1:0]          dir_q;
    logic [IW-1:0]       lastRow_q;
    logic [IW-1:0]       lastCol_q;
    logic                accept_q;
    logic                reject_q;

    logic [CW-1:0]       nextPlayer_d;
    logic [MW-1:0]       moveCount_d;
    logic [CW-1:0]       targetCell;
    logic                canPlace;
    int                  targetIdx;
    logic [RW-1:0]       runLen;

    line_run_counter #(
        .N  (N),
        .K  (K),
        .CW (CW),
        .IW (IW)
    ) u_runCounter (
        .board_i     (board_q),
        .anchorRow_i (lastRow_q),
        .anchorCol_i (lastCol_q),
        .owner_i     (player_q),
        .dir_i       (dir_q),
        .run_o       (runLen)
    );

    // Out-of-range coordinates are legal inputs; they simply cannot be placed
    always_comb begin
        targetIdx  = int'(move_row) * N + int'(move_col);
        targetCell = '0;
        for (int i = 0; i < N * N; i++) begin
            if (i == targetIdx) begin
                targetCell = board_q[i*CW +: CW];
            end
        end
        canPlace     = (int'(move_row) < N) && (int'(move_col) < N) &&
                       (targetCell == CW'(EMPTY));
        nextPlayer_d = (player_q == CW'(PLAYERS)) ? CW'(1) : player_q + CW'(1);
        moveCount_d  = count_q + MW'(1);
    end

    // new_game clears everything exactly like reset, overriding any move
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PLAY;
            board_q   <= '0;
            player_q  <= CW'(1);
            count_q   <= '0;
            winner_q  <= '0;
            draw_q    <= 1'b0;
            dir_q     <= 2'd0;
            lastRow_q <= '0;
            lastCol_q <= '0;
            accept_q  <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            if (new_game) begin
                state_q   <= PLAY;
                board_q   <= '0;
                player_q  <= CW'(1);
                count_q   <= '0;
                winner_q  <= '0;
                draw_q    <= 1'b0;
                dir_q     <= 2'd0;
                lastRow_q <= '0;
                lastCol_q <= '0;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (move_valid) begin
                            if (canPlace) begin
                                for (int i = 0; i < N * N; i++) begin
                                    if (i == targetIdx) begin
                                        board_q[i*CW +: CW] <= player_q;
                                    end
                                end
                                count_q   <= moveCount_d;
                                lastRow_q <= move_row;
                                lastCol_q <= move_col;
                                dir_q     <= 2'd0;
                                accept_q  <= 1'b1;
                                state_q   <= CHECK;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        if (int'(runLen) >= K) begin
                            winner_q <= player_q;
                            state_q  <= OVER;
                        end else if (dir_q == 2'(NUM_DIRS - 1)) begin
                            if (count_q == MW'(N * N)) begin
                                draw_q  <= 1'b1;
                                state_q <= OVER;
                            end else begin
                                player_q <= nextPlayer_d;
                                state_q  <= PLAY;
                            end
                        end else begin
                            dir_q <= dir_q + 2'd1;
                        end
                    end
                    OVER: begin
                        if (move_valid) begin
                            reject_q <= 1'b1;
                        end
                    end
                    default: state_q <= PLAY;
                endcase
            end
        end
    end

    assign move_ready     = (state_q == PLAY);
    assign move_accept    = accept_q;
    assign move_reject    = reject_q;
    assign board          = board_q;
    assign current_player = player_q;
    assign move_count     = count_q;
    assign winner         = winner_q;
    assign draw           = draw_q;
    assign game_over      = (winner_q != '0) || draw_q;

endmodule

// File: tb/tb_board_game_ctrl.sv
// Self-checking bench for board_game_ctrl: a 3x3/K3/2-player and a 5x5/K4/3-player
// instance, scripted games plus random games against a whole-board reference model.
module tb_board_game_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;

    // Instance A: default tic-tac-toe
    logic        newGameA = 1'b0, validA = 1'b0;
    logic [1:0]  rowA = '0, colA = '0;
    logic        readyA, acceptA, rejectA, drawA, overA;
    logic [17:0] boardA;
    logic [1:0]  playerA, winnerA;
    logic [3:0]  countA;

    // Instance B: 5x5, K=4, three players
    logic        newGameB = 1'b0, validB = 1'b0;
    logic [2:0]  rowB = '0, colB = '0;
    logic        readyB, acceptB, rejectB, drawB, overB;
    logic [49:0] boardB;
    logic [1:0]  playerB, winnerB;
    logic [4:0]  countB;

    board_game_ctrl #(.N(3), .K(3), .PLAYERS(2)) dutA (
        .clk(clk), .reset(reset), .new_game(newGameA), .move_valid(validA),
        .move_row(rowA), .move_col(colA), .move_ready(readyA), .move_accept(acceptA),
        .move_reject(rejectA), .board(boardA), .current_player(playerA),
        .move_count(countA), .winner(winnerA), .draw(drawA), .game_over(overA)
    );

    board_game_ctrl #(.N(5), .K(4), .PLAYERS(3)) dutB (
        .clk(clk), .reset(reset), .new_game(newGameB), .move_valid(validB),
        .move_row(rowB), .move_col(colB), .move_ready(readyB), .move_accept(acceptB),
        .move_reject(rejectB), .board(boardB), .current_player(playerB),
        .move_count(countB), .winner(winnerB), .draw(drawB), .game_over(overB)
    );

    always #5 clk = ~clk;

    int sel = 0;
    int numChecks = 0;
    int numBad = 0;

    logic [63:0] obsBoard;
    logic [7:0]  obsPlayer, obsCount, obsWinner;
    logic        obsReady, obsAccept, obsReject, obsDraw, obsOver;

    always_comb begin
        obsBoard  = (sel == 0) ? 64'(boardA)  : 64'(boardB);
        obsPlayer = (sel == 0) ? 8'(playerA)  : 8'(playerB);
        obsCount  = (sel == 0) ? 8'(countA)   : 8'(countB);
        obsWinner = (sel == 0) ? 8'(winnerA)  : 8'(winnerB);
        obsReady  = (sel == 0) ? readyA  : readyB;
        obsAccept = (sel == 0) ? acceptA : acceptB;
        obsReject = (sel == 0) ? rejectA : rejectB;
        obsDraw   = (sel == 0) ? drawA   : drawB;
        obsOver   = (sel == 0) ? overA   : overB;
    end

    // Reference model: plain board array and game rules
    int mb [8][8];
    int mPlayer, mCount, mWinner;
    bit mDraw;

    function automatic int sideN();   return (sel == 0) ? 3 : 5; endfunction
    function automatic int runK();    return (sel == 0) ? 3 : 4; endfunction
    function automatic int nPlayers(); return (sel == 0) ? 2 : 3; endfunction
    function automatic int coordMax(); return (sel == 0) ? 3 : 7; endfunction
    function automatic bit mOver();   return (mWinner != 0) || mDraw; endfunction

    function automatic void modelReset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mb[r][c] = 0;
        mPlayer = 1; mCount = 0; mWinner = 0; mDraw = 0;
    endfunction

    function automatic bit modelLegal(input int r, input int c);
        return !mOver() && r < sideN() && c < sideN() && mb[r][c] == 0;
    endfunction

    // Scan every length-K window on the board for player p
    function automatic bit lineWin(input int p);
        int drs [4] = '{0, 1, 1, 1};
        int dcs [4] = '{1, 0, 1, -1};
        int n = sideN();
        int k = runK();
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int d = 0; d < 4; d++) begin
                    bit all = 1;
                    for (int i = 0; i < k; i++) begin
                        int rr = r + i * drs[d];
                        int cc = c + i * dcs[d];
                        if (rr < 0 || rr >= n || cc < 0 || cc >= n) all = 0;
                        else if (mb[rr][cc] != p) all = 0;
                    end
                    if (all) return 1;
                end
        return 0;
    endfunction

    function automatic void modelPlace(input int r, input int c);
        mb[r][c] = mPlayer;
        mCount++;
        if (lineWin(mPlayer)) mWinner = mPlayer;
        else if (mCount == sideN() * sideN()) mDraw = 1;
        else mPlayer = (mPlayer % nPlayers()) + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numBad++;
            $display("[TB] FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    task automatic checkAll();
        logic [63:0] expBoard;
        int n = sideN();
        expBoard = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                expBoard[(r*n+c)*2 +: 2] = 2'(mb[r][c]);
        checkOutput("board", obsBoard, expBoard);
        checkOutput("player", 64'(obsPlayer), 64'(mPlayer));
        checkOutput("count", 64'(obsCount), 64'(mCount));
        checkOutput("winner", 64'(obsWinner), 64'(mWinner));
        checkOutput("draw", 64'(obsDraw), 64'(mDraw));
        checkOutput("gameOver", 64'(obsOver), 64'(mOver()));
        checkOutput("ready", 64'(obsReady), 64'(!mOver()));
    endtask

    task automatic setMove(input bit v, input int r, input int c);
        if (sel == 0) begin validA = v; rowA = r[1:0]; colA = c[1:0]; end
        else          begin validB = v; rowB = r[2:0]; colB = c[2:0]; end
    endtask

    task automatic setNewGame(input bit v);
        if (sel == 0) newGameA = v; else newGameB = v;
    endtask

    task automatic pulseNewGame(input bit withMove);
        @(negedge clk);
        setNewGame(1);
        if (withMove) setMove(1, 1, 1);
        @(posedge clk); #1;
        checkOutput("ngAccept", 64'(obsAccept), 64'(0));
        checkOutput("ngReject", 64'(obsReject), 64'(0));
        setNewGame(0);
        setMove(0, 0, 0);
        modelReset();
        checkAll();
    endtask

    // Drive one move; expWinCycles>0 pins the cycle on which a win must land
    task automatic applyStimulus(input int r, input int c, input bit noise, input int expWinCycles);
        bit expAcc;
        bit done;
        int n;
        expAcc = modelLegal(r, c);
        @(negedge clk);
        setMove(1, r, c);
        @(posedge clk); #1;
        checkOutput("accept", 64'(obsAccept), 64'(expAcc));
        checkOutput("reject", 64'(obsReject), 64'(!expAcc));
        setMove(0, 0, 0);
        if (expAcc) begin
            modelPlace(r, c);
            if (noise) setMove(1, $urandom_range(coordMax()), $urandom_range(coordMax()));
            n = 0;
            done = 0;
            while (!done && n < 8) begin
                @(posedge clk); #1;
                n++;
                checkOutput("checkQuiet", {62'b0, obsAccept, obsReject}, 64'(0));
                if (obsReady || obsOver) done = 1;
            end
            setMove(0, 0, 0);
            if (!done) checkOutput("checkTimeout", 64'(n), 64'(4));
            else if (mWinner != 0 && expWinCycles > 0) checkOutput("winCycle", 64'(n), 64'(expWinCycles));
            else if (mWinner != 0) checkOutput("winBound", 64'(n <= 4), 64'(1));
            else checkOutput("checkCycles", 64'(n), 64'(4));
        end
        checkAll();
    endtask

    int rowWin  [5][2] = '{'{0,0}, '{1,0}, '{0,1}, '{1,1}, '{0,2}};
    int drawSeq [9][2] = '{'{0,0}, '{0,1}, '{0,2}, '{1,1}, '{1,0}, '{1,2}, '{2,1}, '{2,0}, '{2,2}};
    int antiSeq [10][2] = '{'{0,3}, '{4,4}, '{4,3}, '{1,2}, '{4,2}, '{3,4}, '{2,1}, '{2,4}, '{0,0}, '{3,0}};

    initial begin
        // Reset values on both instances
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        sel = 0; modelReset(); checkAll();
        sel = 1; modelReset(); checkAll();

        // Row win, then a move in OVER is refused
        sel = 0;
        for (int i = 0; i < 5; i++) applyStimulus(rowWin[i][0], rowWin[i][1], 0, (i == 4) ? 1 : 0);
        applyStimulus(2, 2, 0, 0);

        // new_game from OVER, then a full-board draw
        pulseNewGame(0);
        for (int i = 0; i < 9; i++) applyStimulus(drawSeq[i][0], drawSeq[i][1], 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Occupied and out-of-range rejects
        pulseNewGame(0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(3, 0, 0, 0);
        applyStimulus(1, 3, 0, 0);

        // new_game coincident with move_valid: the move is dropped
        pulseNewGame(1);

        // Async reset in the middle of a check
        applyStimulus(2, 2, 0, 0);
        @(negedge clk);
        setMove(1, 1, 1);
        @(posedge clk); #1;
        checkOutput("preResetAccept", 64'(obsAccept), 64'(1));
        setMove(0, 0, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkAll();

        // Anti-diagonal win on the 5x5 instance, lands on the last direction
        sel = 1;
        pulseNewGame(0);
        for (int i = 0; i < 10; i++) applyStimulus(antiSeq[i][0], antiSeq[i][1], 1, (i == 9) ? 4 : 0);
        applyStimulus(4, 0, 0, 0);

        // Random games on both instances
        for (int g = 0; g < 10; g++) begin
            sel = g % 2;
            pulseNewGame(0);
            for (int m = 0; m < 45 && !mOver(); m++) begin
                if ($urandom_range(40) == 0) pulseNewGame($urandom_range(1));
                else if ($urandom_range(3) == 0) begin
                    int r = $urandom_range(sideN() - 1);
                    int c = $urandom_range(sideN() - 1);
                    applyStimulus(r, c, 1'($urandom_range(1)), 0);
                end else begin
                    applyStimulus($urandom_range(coordMax()), $urandom_range(coordMax()),
                                  1'($urandom_range(1)), 0);
                end
            end
            applyStimulus($urandom_range(coordMax()), $urandom_range(coordMax()), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", numChecks, numBad);
        $finish;
    end

endmodule
